// File: rtl/cdc_in_arbiter_if.sv
// Handshake bundle between byte-stream requesters and the CDC IN stream.
// The arbiter takes the slave side; the requesters/CDC endpoint take the master side.
interface cdc_in_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              configured_i;
    logic [7:0]        in_data_o;
    logic              in_valid_o;
    logic              in_ready_i;
    logic [1:0]        gnt_o;
    logic              busy_o;
    logic              abort_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, configured_i, in_ready_i,
        output req_ready_o, in_data_o, in_valid_o, gnt_o, busy_o, abort_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, configured_i, in_ready_i,
        input  req_ready_o, in_data_o, in_valid_o, gnt_o, busy_o, abort_o
    );
endinterface

// File: rtl/cdc_in_arbiter.sv
// Round-robin arbiter merging NREQ byte streams into one CDC IN stream as
// header-prefixed bursts of at most MAX_BURST data bytes.
module cdc_in_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    cdc_in_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t          state;
    logic [1:0]      gnt;
    logic [1:0]      rr_ptr;
    logic [CW-1:0]   burst_cnt;
    logic            abort;
    logic            busy;

    logic            gnt_valid;
    logic            gnt_last;
    logic [7:0]      gnt_data;
    logic            in_valid;
    logic [7:0]      in_data;
    logic [NREQ-1:0] req_ready;
    logic            xfer;
    logic            burst_end;

    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] v, input logic [1:0] ptr);
        logic found;
        int   idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && v[idx]) begin
                rr_pick = 2'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        next_idx = (int'(idx) == NREQ - 1) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == 2'(i)) begin
                gnt_valid = bus.req_valid_i[i];
                gnt_last  = bus.req_last_i[i];
                gnt_data  = bus.req_data_i[8*i +: 8];
            end
        end
    end

    // Unconfigured device masks every handshake so nothing moves that cycle.
    always_comb begin
        in_valid  = 1'b0;
        in_data   = 8'h00;
        req_ready = '0;
        case (state)
            HDR: begin
                in_valid = bus.configured_i;
                in_data  = {4'hA, 2'b00, gnt};
            end
            DATA: begin
                in_valid = gnt_valid && bus.configured_i;
                in_data  = gnt_data;
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt == 2'(i)) begin
                        req_ready[i] = bus.in_ready_i && bus.configured_i;
                    end
                end
            end
            default: ;
        endcase
    end

    assign xfer      = in_valid && bus.in_ready_i;
    assign burst_end = gnt_last || (burst_cnt == CW'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 2'd0;
            rr_ptr    <= 2'd0;
            burst_cnt <= '0;
            abort     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.configured_i && |bus.req_valid_i) begin
                        gnt   <= rr_pick(bus.req_valid_i, rr_ptr);
                        state <= HDR;
                        busy  <= 1'b1;
                    end
                end
                HDR: begin
                    // rr_ptr is left alone on abort so the same requester wins again.
                    if (!bus.configured_i) begin
                        state <= IDLE;
                        abort <= 1'b1;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        state     <= DATA;
                        burst_cnt <= '0;
                    end
                end
                DATA: begin
                    if (!bus.configured_i) begin
                        state <= IDLE;
                        abort <= 1'b1;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        if (burst_end) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            rr_ptr    <= next_idx(gnt);
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_valid_o  = in_valid;
    assign bus.in_data_o   = in_data;
    assign bus.req_ready_o = req_ready;
    assign bus.gnt_o       = gnt;
    assign bus.busy_o      = busy;
    assign bus.abort_o     = abort;
endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Bench for cdc_in_arbiter: requesters replay per-channel byte queues and the
// CDC stream is compared with a burst-level model of the arbitration rules.
module tb_cdc_in_arbiter;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdc_in_arbiter_if #(.NREQ(NREQ)) bus ();

    cdc_in_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] rq_mem [NREQ][256];
    int         rq_head [NREQ];
    int         rq_tail [NREQ];
    logic [7:0] exp_q [$];

    int rr_model   = 0;
    bit cfg        = 1'b1;
    int ir_mode    = 0;
    bit tog        = 1'b0;
    bit in_burst   = 1'b0;
    bit gap_pending = 1'b0;
    int cur_g      = 0;
    int bcnt       = 0;
    int abort_seen = 0;

    function automatic bit queues_empty();
        for (int i = 0; i < NREQ; i++)
            if (rq_head[i] < rq_tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(input int r, input logic [7:0] d, input bit last);
        if (rq_head[r] == rq_tail[r]) begin
            rq_head[r] = 0;
            rq_tail[r] = 0;
        end
        rq_mem[r][rq_tail[r]] = {last, d};
        rq_tail[r]++;
    endtask

    // Expected CDC stream: round-robin over non-empty channels, header then
    // bytes up to the last flag or MAX_BURST, pointer moves past the winner.
    task automatic build_expected();
        int h [NREQ];
        int g, idx, n;
        bit done;
        logic [8:0] e;
        for (int i = 0; i < NREQ; i++) h[i] = rq_head[i];
        while (1'b1) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr_model + k) % NREQ;
                if (g < 0 && h[idx] < rq_tail[idx]) g = idx;
            end
            if (g < 0) break;
            exp_q.push_back(8'hA0 | 8'(g));
            n = 0;
            done = 1'b0;
            while (!done) begin
                e = rq_mem[g][h[g]];
                exp_q.push_back(e[7:0]);
                h[g]++;
                n++;
                done = e[8] || (n == MAX_BURST) || (h[g] == rq_tail[g]);
            end
            rr_model = (g + 1) % NREQ;
        end
    endtask

    task automatic drive_inputs();
        bit v;
        for (int i = 0; i < NREQ; i++) begin
            v = rq_head[i] < rq_tail[i];
            bus.req_valid_i[i]        = v;
            bus.req_data_i[8*i +: 8]  = v ? rq_mem[i][rq_head[i]][7:0] : 8'($urandom);
            bus.req_last_i[i]         = v ? rq_mem[i][rq_head[i]][8] : 1'b0;
        end
        bus.configured_i = cfg;
        case (ir_mode)
            1: begin
                tog = ~tog;
                bus.in_ready_i = tog;
            end
            2: bus.in_ready_i = ($urandom_range(0, 3) != 0);
            default: bus.in_ready_i = 1'b1;
        endcase
    endtask

    task automatic run_cycle();
        logic [NREQ-1:0] er;
        logic [7:0] want;
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        er = '0;
        if (cfg && in_burst) er[cur_g] = bus.in_ready_i;
        checks++;
        if (bus.req_ready_o !== er) begin
            errors++;
            $display("FAIL req_ready: got %b want %b", bus.req_ready_o, er);
        end
        if (!cfg) begin
            checks++;
            if (bus.in_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL unconfigured_valid: got %b want 0", bus.in_valid_o);
            end
        end else begin
            if (in_burst) begin
                checks++;
                if (bus.in_valid_o !== bus.req_valid_i[cur_g]) begin
                    errors++;
                    $display("FAIL data_valid: got %b want %b", bus.in_valid_o, bus.req_valid_i[cur_g]);
                end
                checks++;
                if (bus.gnt_o !== 2'(cur_g)) begin
                    errors++;
                    $display("FAIL gnt: got %0d want %0d", bus.gnt_o, cur_g);
                end
            end
            if (gap_pending) begin
                checks++;
                if (bus.in_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL gap: got in_valid %b want 0", bus.in_valid_o);
                end
            end
            if (!in_burst && bus.in_valid_o === 1'b0) begin
                checks++;
                if (bus.in_data_o !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_data: got %h want 00", bus.in_data_o);
                end
            end
        end
        gap_pending = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (bus.req_valid_i[i] && bus.req_ready_o[i]) rq_head[i]++;
        if (bus.in_valid_o === 1'b1 && bus.in_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream: got unexpected byte %h want none", bus.in_data_o);
            end else begin
                want = exp_q.pop_front();
                if (bus.in_data_o !== want) begin
                    errors++;
                    $display("FAIL stream: got %h want %h", bus.in_data_o, want);
                end
            end
            if (!in_burst) begin
                in_burst = 1'b1;
                cur_g    = int'(bus.in_data_o[1:0]);
                bcnt     = 0;
            end else begin
                bcnt++;
                if (bus.req_last_i[cur_g] || bcnt == MAX_BURST) begin
                    in_burst    = 1'b0;
                    gap_pending = 1'b1;
                end
            end
        end
        if (bus.abort_o === 1'b1) abort_seen++;
    endtask

    task automatic run_stream(input int leave);
        int cyc = 0;
        while (!(exp_q.size() <= leave && (leave > 0 || queues_empty())) && cyc < 2000) begin
            run_cycle();
            cyc++;
        end
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL stream_timeout: got %0d bytes outstanding want %0d", exp_q.size(), leave);
        end
        if (leave == 0) begin
            repeat (2) run_cycle();
            checks++;
            if (bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy: got %b want 0", bus.busy_o);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.in_valid_o !== 1'b0 || bus.in_data_o !== 8'h00 ||
            bus.req_ready_o !== '0 || bus.gnt_o !== 2'd0 || bus.abort_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got busy=%b valid=%b data=%h ready=%b gnt=%0d abort=%b want all zero",
                     tag, bus.busy_o, bus.in_valid_o, bus.in_data_o, bus.req_ready_o, bus.gnt_o, bus.abort_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ir_mode = 0;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_model = 0;
        in_burst = 1'b0;
        gap_pending = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_single();
        ir_mode = 0;
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        build_expected();
        run_stream(0);
        checks++;
        if (bus.gnt_o !== 2'd1) begin
            errors++;
            $display("FAIL single_gnt: got %0d want 1", bus.gnt_o);
        end
    endtask

    task automatic test_burst_limit();
        ir_mode = 0;
        for (int b = 1; b <= 12; b++) push_byte(0, 8'(b), b == 12);
        build_expected();
        run_stream(0);
    endtask

    task automatic test_round_robin();
        ir_mode = 0;
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < NREQ; i++) push_byte(i, 8'(16 * i + rep + 1), 1'b1);
        build_expected();
        run_stream(0);
    endtask

    task automatic test_backpressure();
        ir_mode = 1;
        tog = 1'b0;
        for (int b = 0; b < 5; b++) push_byte(2, 8'h50 + 8'(b), b == 4);
        build_expected();
        run_stream(0);
        ir_mode = 0;
    endtask

    task automatic test_abort();
        int saved_rr, a0;
        ir_mode = 0;
        push_byte(2, 8'h77, 1'b1);
        build_expected();
        run_stream(0);
        for (int b = 0; b < 5; b++) push_byte(3, 8'hC1 + 8'(b), b == 4);
        saved_rr = rr_model;
        build_expected();
        run_stream(3);
        a0 = abort_seen;
        push_byte(0, 8'h0E, 1'b1);
        cfg = 1'b0;
        repeat (3) run_cycle();
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b want 0", bus.busy_o);
        end
        cfg = 1'b1;
        in_burst = 1'b0;
        gap_pending = 1'b0;
        rr_model = saved_rr;
        exp_q.delete();
        build_expected();
        run_stream(0);
        checks++;
        if (abort_seen - a0 != 1) begin
            errors++;
            $display("FAIL abort_pulses: got %0d want 1", abort_seen - a0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int a0;
        ir_mode = 0;
        for (int b = 0; b < 6; b++) push_byte(1, 8'h91 + 8'(b), b == 5);
        build_expected();
        run_stream(4);
        a0 = abort_seen;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive_inputs();
        bus.in_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.abort_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_abort: got %b want 0", bus.abort_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
        @(negedge clk);
        check_reset_outputs("reset_mid_burst");
        rr_model = 0;
        in_burst = 1'b0;
        gap_pending = 1'b0;
        exp_q.delete();
        build_expected();
        run_stream(0);
        checks++;
        if (abort_seen != a0) begin
            errors++;
            $display("FAIL reset_abort: got %0d pulses want 0", abort_seen - a0);
        end
    endtask

    task automatic test_random();
        int a0, nb, len;
        a0 = abort_seen;
        ir_mode = 2;
        for (int round = 0; round < 15; round++) begin
            for (int i = 0; i < NREQ; i++) begin
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(1, MAX_BURST + 3);
                    for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), k == len - 1);
                end
            end
            build_expected();
            run_stream(0);
        end
        checks++;
        if (abort_seen != a0) begin
            errors++;
            $display("FAIL random_abort: got %0d pulses want 0", abort_seen - a0);
        end
        ir_mode = 0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        bus.req_valid_i  = '0;
        bus.req_data_i   = '0;
        bus.req_last_i   = '0;
        bus.configured_i = 1'b1;
        bus.in_ready_i   = 1'b1;

        test_reset();
        test_single();
        test_burst_limit();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_reset_mid_burst();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdc_in_arbiter.md
CDC_IN_ARBITER -- requirements
Module: cdc_in_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte-stream requesters (legal 2..4).
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum data bytes per burst, matching the CDC IN bulk max packet size (legal 2..64).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port req_valid_i, input, NREQ, per-requester byte valid.
REQ-006 SHALL have port req_data_i, input, 8*NREQ, per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_last_i, input, NREQ, marks the requester's final byte of the current burst.
REQ-008 SHALL have port req_ready_o, output, NREQ, per-requester byte accepted.
REQ-009 SHALL have port configured_i, input, 1, CDC device configured status.
REQ-010 SHALL have port in_data_o, output, 8, byte to the CDC IN stream.
REQ-011 SHALL have port in_valid_o, output, 1, CDC IN byte valid.
REQ-012 SHALL have port in_ready_i, input, 1, CDC IN byte accepted.
REQ-013 SHALL have port gnt_o, output, 2, index of the current or last granted requester.
REQ-014 SHALL have port busy_o, output, 1, high in the HDR and DATA states.
REQ-015 SHALL have port abort_o, output, 1, one-cycle pulse when a burst is aborted.

Function
REQ-016 A transfer SHALL occur on any channel in a cycle where its valid and ready are both high; a requester holds valid and data stable until the transfer.
REQ-017 The FSM SHALL have exactly three states: IDLE, HDR and DATA.
REQ-018 In IDLE, when configured_i=1 and any req_valid_i bit is high, the FSM SHALL grant the first asserting index found searching upward from rr_ptr (wrapping modulo NREQ), latch it into gnt_o, and enter HDR on the next cycle.
REQ-019 In HDR, in_valid_o SHALL be 1 and in_data_o SHALL be {4'hA, 2'b00, gnt}; on transfer the FSM SHALL enter DATA with burst_cnt=0.
REQ-020 In HDR, all req_ready_o bits SHALL be 0.
REQ-021 In DATA, the datapath SHALL be combinational pass-through for the granted requester only: in_valid_o=req_valid_i[gnt], in_data_o=req_data_i[gnt], req_ready_o[gnt]=in_ready_i; all other req_ready_o bits SHALL be 0.
REQ-022 In DATA, each transfer SHALL increment burst_cnt.
REQ-023 In DATA, a transfer with req_last_i[gnt]=1 or burst_cnt=MAX_BURST-1 SHALL return the FSM to IDLE and set rr_ptr=(gnt+1) mod NREQ.
REQ-024 burst_cnt SHALL be $clog2(MAX_BURST) bits wide and SHALL never wrap within a burst.
REQ-025 In IDLE, in_valid_o SHALL be 0, all req_ready_o bits SHALL be 0, and in_data_o SHALL be 8'h00.
REQ-026 While configured_i=0, in_valid_o and all req_ready_o bits SHALL be forced to 0 combinationally, so no transfer occurs that cycle.
REQ-027 If configured_i=0 while in HDR or DATA, the FSM SHALL go to IDLE on the next cycle, pulse abort_o for that one cycle, and leave rr_ptr unchanged so the same requester is regranted first.
REQ-028 If configured_i=0 in IDLE, the FSM SHALL stay in IDLE with no abort pulse.
REQ-029 If req_valid_i[gnt] drops mid-DATA, the FSM SHALL remain in DATA with in_valid_o=0 (no timeout).
REQ-030 A request arriving on the cycle a burst ends SHALL be arbitrated in the following IDLE cycle, giving a minimum one-cycle gap between bursts.

Reset
REQ-031 On rst_n=0 at a clk edge, the block SHALL set: state=IDLE, rr_ptr=0, gnt_o=0, burst_cnt=0, abort_o=0.
REQ-032 Consequently, after reset busy_o=0, in_valid_o=0, in_data_o=8'h00 and all req_ready_o bits are 0.
REQ-033 Reset mid-burst SHALL discard the burst without an abort pulse.

Verification
REQ-034 Single requester: configured=1, req1 sends 3 bytes 11,22,33 with last on 33 and in_ready always 1 -> CDC sees A1,11,22,33; IDLE follows; rr_ptr=2.
REQ-035 Burst limit: req0 streams 12 bytes with no last, MAX_BURST=8 -> A0 plus 8 bytes; one IDLE cycle; then A0 plus the remaining 4 bytes (if last on byte 12).
REQ-036 Round-robin: req0..req3 all continuously valid, single-byte bursts -> header order A0,A1,A2,A3,A0.
REQ-037 Backpressure: in_ready toggles 1,0,1,0 during req2's burst -> each byte appears exactly once, in order; req_ready_o[2] mirrors in_ready.
REQ-038 Abort: configured drops after req3's second data byte -> abort_o pulses once; IDLE; when configured returns, req3 is regranted first (A3 header).
REQ-039 Reset: rst_n low for 1 cycle during DATA -> all outputs at reset values next cycle; no abort pulse.
